// File: rtl/level_memory_stage_pkg.sv
// Shared MIPS definitions: opcode/funct codes, the EX/MEM record and the
// register-write decode that the hazard unit also uses.
package mips_defs;

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_ADDI    = 6'b001000;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ANDI    = 6'b001100;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_XORI    = 6'b001110;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LB      = 6'b100000;
  localparam logic [5:0] OP_LH      = 6'b100001;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_LBU     = 6'b100100;
  localparam logic [5:0] OP_LHU     = 6'b100101;
  localparam logic [5:0] OP_SB      = 6'b101000;
  localparam logic [5:0] OP_SH      = 6'b101001;
  localparam logic [5:0] OP_SW      = 6'b101011;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_JALR = 6'b001001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_WORD,
    ST_HALF,
    ST_BYTE
  } store_kind_e;

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc8;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] rt;
    logic [4:0]        wreg;
  } ex_mem_t;

  function automatic store_kind_e store_kind(input logic [5:0] op);
    case (op)
      OP_SW:   return ST_WORD;
      OP_SH:   return ST_HALF;
      OP_SB:   return ST_BYTE;
      default: return ST_NONE;
    endcase
  endfunction

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
           (op == OP_LB) || (op == OP_LBU);
  endfunction

  function automatic logic is_link(input logic [5:0] op, input logic [5:0] fn);
    return (op == OP_JAL) || ((op == OP_SPECIAL) && (fn == FN_JALR));
  endfunction

  // An all-zero word is the canonical nop and must not count as sll.
  function automatic logic regwrite_decode(input logic [DATA_W-1:0] instr,
                                           input logic [4:0]        dest);
    logic [5:0] op;
    logic [5:0] fn;
    logic       rw;
    op = instr[31:26];
    fn = instr[5:0];
    rw = 1'b0;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_ADDU, FN_ADD, FN_SUBU, FN_SUB, FN_AND, FN_OR, FN_XOR, FN_NOR,
        FN_SLT, FN_SLTU, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
        FN_JALR: rw = 1'b1;
        FN_SLL:  rw = (instr != '0);
        default: rw = 1'b0;
      endcase
    end else begin
      case (op)
        OP_ORI, OP_XORI, OP_ANDI, OP_SLTI, OP_SLTIU, OP_ADDI, OP_ADDIU,
        OP_LUI, OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_JAL: rw = 1'b1;
        default: rw = 1'b0;
      endcase
    end
    return rw && (dest != 5'd0);
  endfunction

endpackage

// File: rtl/level_memory_stage_if.sv
// Execute-side inputs and M/W-side outputs of the memory stage.
interface level_memory_stage_if;
  logic [31:0] Instr_E;
  logic [31:0] PC_plus_8_E;
  logic [31:0] ALUResult_E;
  logic [31:0] rt_value_E;
  logic [4:0]  WriteRegNum_E;
  logic [31:0] ALUResult_M;
  logic [31:0] Instr_M;
  logic [4:0]  WriteRegNum_M;
  logic [31:0] Data_out_W;
  logic [4:0]  WriteRegNum_W;
  logic        RegWrite_W;

  modport master (
    output Instr_E, PC_plus_8_E, ALUResult_E, rt_value_E, WriteRegNum_E,
    input  ALUResult_M, Instr_M, WriteRegNum_M, Data_out_W, WriteRegNum_W,
           RegWrite_W
  );

  modport slave (
    input  Instr_E, PC_plus_8_E, ALUResult_E, rt_value_E, WriteRegNum_E,
    output ALUResult_M, Instr_M, WriteRegNum_M, Data_out_W, WriteRegNum_W,
           RegWrite_W
  );
endinterface

// File: rtl/level_memory_stage_data_mem.sv
// Byte-enabled word memory: synchronous write and clear, combinational read.
module data_mem #(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        be,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH];

  // Clear wins over a write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i[ADDR_W-1:0]] <= '0;
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (be[l]) mem[addr][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/level_memory_stage.sv
// MIPS memory stage: EX/MEM register, data memory access with load
// extension, and the MEM/WB register feeding the register file.
module level_memory_stage
  import mips_defs::*;
#(
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input logic                 clk,
  input logic                 reset,
  level_memory_stage_if.slave bus
);

  ex_mem_t           ex_p1;
  logic [5:0]        op_p1;
  logic [5:0]        fn_p1;
  logic [3:0]        be_p1;
  logic [31:0]       wdata_p1;
  logic [31:0]       rdata_p1;
  logic [31:0]       load_p1;
  logic [31:0]       fwd_p1;
  logic [31:0]       wb_p1;
  logic [31:0]       data_p2;
  logic [4:0]        wreg_p2;
  logic              rw_p2;

  function automatic logic [31:0] ext_half(input logic signed [15:0] h,
                                           input logic               sgn);
    return sgn ? 32'(h) : {16'h0000, h};
  endfunction

  function automatic logic [31:0] ext_byte(input logic signed [7:0] b,
                                           input logic              sgn);
    return sgn ? 32'(b) : {24'h000000, b};
  endfunction

  function automatic logic [31:0] load_extract(input logic [5:0]  op,
                                               input logic [1:0]  lo,
                                               input logic [31:0] word);
    logic [15:0] half;
    logic [7:0]  byt;
    half = lo[1] ? word[31:16] : word[15:0];
    byt  = word[8*lo +: 8];
    case (op)
      OP_LH:   return ext_half(half, 1'b1);
      OP_LHU:  return ext_half(half, 1'b0);
      OP_LB:   return ext_byte(byt, 1'b1);
      OP_LBU:  return ext_byte(byt, 1'b0);
      default: return word;
    endcase
  endfunction

  // ---- EX/MEM boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_p1 <= '0;
    end else begin
      ex_p1 <= '{instr: bus.Instr_E,
                 pc8:   bus.PC_plus_8_E,
                 alu:   bus.ALUResult_E,
                 rt:    bus.rt_value_E,
                 wreg:  bus.WriteRegNum_E};
    end
  end

  assign op_p1 = ex_p1.instr[31:26];
  assign fn_p1 = ex_p1.instr[5:0];

  always_comb begin
    be_p1    = 4'b0000;
    wdata_p1 = '0;
    case (store_kind(op_p1))
      ST_WORD: begin
        be_p1    = 4'b1111;
        wdata_p1 = ex_p1.rt;
      end
      ST_HALF: begin
        be_p1    = ex_p1.alu[1] ? 4'b1100 : 4'b0011;
        wdata_p1 = {2{ex_p1.rt[15:0]}};
      end
      ST_BYTE: begin
        be_p1    = 4'b0001 << ex_p1.alu[1:0];
        wdata_p1 = {4{ex_p1.rt[7:0]}};
      end
      default: begin
        be_p1    = 4'b0000;
        wdata_p1 = '0;
      end
    endcase
  end

  // Upper address bits above the memory size are dropped, so accesses wrap.
  data_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_data_mem (
    .clk   (clk),
    .reset (reset),
    .addr  (ex_p1.alu[ADDR_W+1:2]),
    .be    (be_p1),
    .wdata (wdata_p1),
    .rdata (rdata_p1)
  );

  assign load_p1 = load_extract(op_p1, ex_p1.alu[1:0], rdata_p1);
  assign fwd_p1  = is_link(op_p1, fn_p1) ? ex_p1.pc8 : ex_p1.alu;
  assign wb_p1   = is_load(op_p1) ? load_p1 : fwd_p1;

  // ---- MEM/WB boundary ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p2 <= '0;
      wreg_p2 <= '0;
      rw_p2   <= 1'b0;
    end else begin
      data_p2 <= wb_p1;
      wreg_p2 <= ex_p1.wreg;
      rw_p2   <= regwrite_decode(ex_p1.instr, ex_p1.wreg);
    end
  end

  assign bus.ALUResult_M   = fwd_p1;
  assign bus.Instr_M       = ex_p1.instr;
  assign bus.WriteRegNum_M = ex_p1.wreg;
  assign bus.Data_out_W    = data_p2;
  assign bus.WriteRegNum_W = wreg_p2;
  assign bus.RegWrite_W    = rw_p2;

endmodule

// File: tb/tb_level_memory_stage.sv
// Bench for level_memory_stage: directed vector table, reset sequence and
// randomized traffic against a byte-array reference model.
module tb_level_memory_stage;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  level_memory_stage_if bus();

  level_memory_stage #(.DEPTH(1024), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] rt;
    logic [4:0]  wreg;
  } ex_t;

  typedef struct {
    ex_t         in;
    bit          chk_w;
    logic [31:0] data_w;
    logic [4:0]  wreg_w;
    logic        rw_w;
    bit          chk_m;
    logic [31:0] alu_m;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mb [0:4095];
  ex_t         m_cur;
  logic [31:0] exp_data_w;
  logic [4:0]  exp_wreg_w;
  logic        exp_rw_w;
  vec_t        tbl [18];

  function automatic ex_t mk_ex(logic [31:0] instr, logic [31:0] pc8,
                                logic [31:0] alu, logic [31:0] rt, logic [4:0] wreg);
    ex_t e;
    e.instr = instr; e.pc8 = pc8; e.alu = alu; e.rt = rt; e.wreg = wreg;
    return e;
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] op, logic [4:0] rs,
                                       logic [4:0] rt, logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(logic [5:0] fn, logic [4:0] rs,
                                       logic [4:0] rt, logic [4:0] rd);
    return {6'd0, rs, rt, rd, 5'd0, fn};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic logic m_regwrite(logic [31:0] ins, logic [4:0] d);
    int op = int'(ins[31:26]);
    int fn = int'(ins[5:0]);
    if (d == 5'd0) return 1'b0;
    if (op == 0)
      return (fn inside {33, 32, 35, 34, 36, 37, 38, 39, 42, 43, 2, 3, 4, 6, 7, 9}) ||
             (fn == 0 && ins != 32'd0);
    return op inside {13, 14, 12, 10, 11, 8, 9, 15, 35, 33, 37, 32, 36, 3};
  endfunction

  function automatic logic [31:0] m_fwd(ex_t e);
    int op = int'(e.instr[31:26]);
    int fn = int'(e.instr[5:0]);
    if (op == 3 || (op == 0 && fn == 9)) return e.pc8;
    return e.alu;
  endfunction

  // Advance the model across one clock edge.
  task automatic model_edge(ex_t nxt, logic rst);
    int op, a, aw, ah, sv;
    logic [31:0] val;
    logic [15:0] h;
    if (rst) begin
      for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
      m_cur = mk_ex(0, 0, 0, 0, 0);
      exp_data_w = 0; exp_wreg_w = 0; exp_rw_w = 0;
      return;
    end
    op = int'(m_cur.instr[31:26]);
    a  = int'(m_cur.alu % 4096);
    aw = a - (a % 4);
    ah = a - (a % 2);
    val = m_fwd(m_cur);
    h = {mb[ah+1], mb[ah]};
    case (op)
      35: val = {mb[aw+3], mb[aw+2], mb[aw+1], mb[aw]};
      33: begin sv = int'($signed(h)); val = sv; end
      37: val = 32'(h);
      32: begin sv = int'($signed(mb[a])); val = sv; end
      36: val = 32'(mb[a]);
      default: ;
    endcase
    exp_data_w = val;
    exp_wreg_w = m_cur.wreg;
    exp_rw_w   = m_regwrite(m_cur.instr, m_cur.wreg);
    case (op)
      43: for (int k = 0; k < 4; k++) mb[aw+k] = m_cur.rt[8*k +: 8];
      41: begin mb[ah] = m_cur.rt[7:0]; mb[ah+1] = m_cur.rt[15:8]; end
      40: mb[a] = m_cur.rt[7:0];
      default: ;
    endcase
    m_cur = nxt;
  endtask

  task automatic step(ex_t x, logic r);
    reset             = r;
    bus.Instr_E       = x.instr;
    bus.PC_plus_8_E   = x.pc8;
    bus.ALUResult_E   = x.alu;
    bus.rt_value_E    = x.rt;
    bus.WriteRegNum_E = x.wreg;
    @(posedge clk);
    model_edge(x, r);
    #1;
    chk("ALUResult_M", bus.ALUResult_M, m_fwd(m_cur));
    chk("Instr_M", bus.Instr_M, m_cur.instr);
    chk("WriteRegNum_M", 32'(bus.WriteRegNum_M), 32'(m_cur.wreg));
    chk("Data_out_W", bus.Data_out_W, exp_data_w);
    chk("WriteRegNum_W", 32'(bus.WriteRegNum_W), 32'(exp_wreg_w));
    chk("RegWrite_W", 32'(bus.RegWrite_W), 32'(exp_rw_w));
  endtask

  function automatic logic [31:0] rand_instr();
    logic [4:0] rs = 5'($urandom);
    logic [4:0] rt = 5'($urandom);
    logic [15:0] im = 16'($urandom);
    case ($urandom_range(0, 14))
      0:  return mk_i(6'h2B, rs, rt, im);
      1:  return mk_i(6'h29, rs, rt, im);
      2:  return mk_i(6'h28, rs, rt, im);
      3:  return mk_i(6'h23, rs, rt, im);
      4:  return mk_i(6'h21, rs, rt, im);
      5:  return mk_i(6'h25, rs, rt, im);
      6:  return mk_i(6'h20, rs, rt, im);
      7:  return mk_i(6'h24, rs, rt, im);
      8:  return mk_r(6'($urandom_range(0, 63)), rs, rt, 5'($urandom));
      9:  return {6'h03, 26'($urandom)};
      10: return mk_r(6'h09, rs, 5'd0, 5'd31);
      11: return mk_i(6'($urandom_range(8, 15)), rs, rt, im);
      12: return 32'd0;
      13: return mk_i(6'h04, rs, rt, im);
      default: return $urandom;
    endcase
  endfunction

  ex_t nop_e;
  ex_t rx;

  initial begin
    nop_e = mk_ex(0, 0, 0, 0, 0);

    tbl[0]  = '{mk_ex(mk_i(6'h2B, 1, 2, 16'h10), 32'h100, 32'h10, 32'hDEADBEEF, 5), 0, 0, 0, 0, 1, 32'h10};
    tbl[1]  = '{mk_ex(mk_i(6'h23, 1, 8, 16'h10), 32'h108, 32'h10, 32'h0, 8), 1, 32'h10, 5, 0, 0, 0};
    tbl[2]  = '{nop_e, 1, 32'hDEADBEEF, 8, 1, 0, 0};
    tbl[3]  = '{mk_ex(mk_i(6'h29, 1, 2, 16'h22), 32'h0, 32'h22, 32'h00008001, 0), 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{mk_ex(mk_i(6'h28, 1, 2, 16'h20), 32'h0, 32'h20, 32'h0000007F, 0), 0, 0, 0, 0, 0, 0};
    tbl[5]  = '{mk_ex(mk_i(6'h23, 1, 9, 16'h20), 32'h0, 32'h20, 32'h0, 9), 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{mk_ex(mk_i(6'h21, 1, 10, 16'h22), 32'h0, 32'h22, 32'h0, 10), 1, 32'h8001007F, 9, 1, 0, 0};
    tbl[7]  = '{mk_ex(mk_i(6'h25, 1, 11, 16'h22), 32'h0, 32'h22, 32'h0, 11), 1, 32'hFFFF8001, 10, 1, 0, 0};
    tbl[8]  = '{mk_ex(mk_i(6'h20, 1, 12, 16'h20), 32'h0, 32'h20, 32'h0, 12), 1, 32'h00008001, 11, 1, 0, 0};
    tbl[9]  = '{mk_ex({6'h03, 26'h0000C00}, 32'h3008, 32'h1234, 32'h0, 31), 1, 32'h0000007F, 12, 1, 1, 32'h3008};
    tbl[10] = '{mk_ex(mk_r(6'h21, 1, 2, 0), 32'h0, 32'h5, 32'h0, 0), 1, 32'h3008, 31, 1, 0, 0};
    tbl[11] = '{mk_ex(mk_i(6'h04, 1, 2, 16'h4), 32'h0, 32'h44, 32'h0, 5), 1, 32'h5, 0, 0, 0, 0};
    tbl[12] = '{mk_ex({6'h02, 26'h100}, 32'h0, 32'h55, 32'h0, 5), 1, 32'h44, 5, 0, 0, 0};
    tbl[13] = '{mk_ex(mk_r(6'h08, 31, 0, 0), 32'h0, 32'h77, 32'h0, 5), 1, 32'h55, 5, 0, 0, 0};
    tbl[14] = '{nop_e, 1, 32'h77, 5, 0, 0, 0};
    tbl[15] = '{mk_ex(mk_i(6'h2B, 1, 2, 16'h1004), 32'h0, 32'h1004, 32'hCAFEF00D, 0), 1, 32'h0, 0, 0, 0, 0};
    tbl[16] = '{mk_ex(mk_i(6'h23, 1, 3, 16'h0004), 32'h0, 32'h0004, 32'h0, 3), 1, 32'h1004, 0, 0, 0, 0};
    tbl[17] = '{nop_e, 1, 32'hCAFEF00D, 3, 1, 0, 0};

    // Power-on reset: everything must read as a nop.
    step(nop_e, 1'b1);
    step(nop_e, 1'b1);
    chk("reset Data_out_W", bus.Data_out_W, 32'h0);
    chk("reset RegWrite_W", 32'(bus.RegWrite_W), 32'h0);
    chk("reset Instr_M", bus.Instr_M, 32'h0);

    for (int i = 0; i < 18; i++) begin
      step(tbl[i].in, 1'b0);
      if (tbl[i].chk_w) begin
        chk($sformatf("vec%0d Data_out_W", i), bus.Data_out_W, tbl[i].data_w);
        chk($sformatf("vec%0d WriteRegNum_W", i), 32'(bus.WriteRegNum_W), 32'(tbl[i].wreg_w));
        chk($sformatf("vec%0d RegWrite_W", i), 32'(bus.RegWrite_W), 32'(tbl[i].rw_w));
      end
      if (tbl[i].chk_m)
        chk($sformatf("vec%0d ALUResult_M", i), bus.ALUResult_M, tbl[i].alu_m);
    end

    // A store sitting in M while reset is asserted must be dropped.
    step(mk_ex(mk_i(6'h2B, 1, 2, 16'h40), 32'h0, 32'h40, 32'h11223344, 0), 1'b0);
    step(nop_e, 1'b1);
    chk("midreset ALUResult_M", bus.ALUResult_M, 32'h0);
    chk("midreset Instr_M", bus.Instr_M, 32'h0);
    chk("midreset Data_out_W", bus.Data_out_W, 32'h0);
    chk("midreset RegWrite_W", 32'(bus.RegWrite_W), 32'h0);
    step(mk_ex(mk_i(6'h23, 1, 4, 16'h40), 32'h0, 32'h40, 32'h0, 4), 1'b0);
    step(nop_e, 1'b0);
    chk("dropped store Data_out_W", bus.Data_out_W, 32'h0);
    chk("dropped store RegWrite_W", 32'(bus.RegWrite_W), 32'h1);

    // Random traffic concentrated on a small address window, high bits random.
    for (int n = 0; n < 600; n++) begin
      rx.instr = rand_instr();
      rx.pc8   = $urandom;
      rx.alu   = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) rx.alu = $urandom;
      rx.rt    = $urandom;
      rx.wreg  = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      step(rx, ($urandom_range(0, 79) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
